// File: rtl/tone_queue.sv
// tone_queue: buffers note entries in a small FIFO and plays them back one at a
// time as a (freq, duty) pair for a downstream PWM generator, inserting a silent
// gap after every note.
module tone_queue #(
   parameter int unsigned BEAT_CYCLES = 25_000_000,
   parameter int unsigned GAP_CYCLES  = 1_000_000,
   parameter int unsigned DEPTH       = 8,
   parameter logic [9:0]  DUTY_ON     = 10'd512,
   parameter logic [31:0] REST_FREQ   = 32'd1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_note,
   input  logic [1:0]  in_oct,
   input  logic [1:0]  in_beats,
   input  logic        flush,
   output logic [31:0] freq,
   output logic [9:0]  duty,
   output logic        busy,
   output logic        note_done,
   output logic [3:0]  level
);

   localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [3:0]  DEPTH_L   = 4'(DEPTH);
   localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
   localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   typedef struct packed {
      logic [3:0] note;
      logic [1:0] oct;
      logic [1:0] beats;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           wr_entry;
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             ready_en;
   logic             push, pop, load;

   state_t      state, state_d;
   logic [31:0] cyc_cnt, cyc_d;
   logic [31:0] beat_cnt, beat_d;
   logic [1:0]  beats_q, beats_d;
   logic [31:0] freq_d;
   logic [9:0]  duty_d;
   logic        done_d;

   // Advance a FIFO pointer, wrapping after the last entry.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Base frequency in Hz of notes 1..12 (C..B); rests never use this table.
   function automatic logic [8:0] base_hz(input logic [3:0] n);
      case (n)
         4'd1:    return 9'd262;
         4'd2:    return 9'd277;
         4'd3:    return 9'd294;
         4'd4:    return 9'd311;
         4'd5:    return 9'd330;
         4'd6:    return 9'd349;
         4'd7:    return 9'd370;
         4'd8:    return 9'd392;
         4'd9:    return 9'd415;
         4'd10:   return 9'd440;
         4'd11:   return 9'd466;
         4'd12:   return 9'd494;
         default: return 9'd0;
      endcase
   endfunction

   // ready_en keeps in_ready low through reset and for the reset edge itself.
   assign in_ready = ready_en && (level < DEPTH_L) && !flush;
   assign push     = in_valid && in_ready;
   assign wr_entry = {in_note, in_oct, in_beats};
   assign head     = mem[rd_ptr];
   assign busy     = (state != IDLE);

   // Note storage: written on an accepted entry.
   // NOTE: the storage array has no reset; pointers and level define which entries are valid.
   always_ff @(posedge clk) begin
      if (rst_n && push) mem[wr_ptr] <= wr_entry;
   end

   // FIFO pointers and occupancy; flush wins over any push or pop.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
               2'b10:   level <= level + 1'b1;
               2'b01:   level <= level - 1'b1;
               default: level <= level;
            endcase
         end
      end
   end

   // Next-state and next-output logic for the IDLE / PLAY / GAP sequencer.
   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state;
      cyc_d   = cyc_cnt;
      beat_d  = beat_cnt;
      beats_d = beats_q;
      freq_d  = freq;
      duty_d  = duty;
      done_d  = 1'b0;
      load    = 1'b0;
      pop     = 1'b0;

      unique case (state)
         IDLE: begin
            if (level != 4'd0) load = 1'b1;
         end
         PLAY: begin
            if (cyc_cnt == BEAT_LAST) begin
               cyc_d = '0;
               if (beat_cnt == 32'(beats_q)) begin
                  state_d = GAP;
                  beat_d  = '0;
                  duty_d  = 10'd0;
                  done_d  = 1'b1;
               end else begin
                  beat_d = beat_cnt + 32'd1;
               end
            end else begin
               cyc_d = cyc_cnt + 32'd1;
            end
         end
         GAP: begin
            if (cyc_cnt == GAP_LAST) begin
               cyc_d = '0;
               if (level != 4'd0) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
                  freq_d  = REST_FREQ;
               end
            end else begin
               cyc_d = cyc_cnt + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Pop the head entry and register its tone at the same edge.
      if (load) begin
         pop     = 1'b1;
         state_d = PLAY;
         cyc_d   = '0;
         beat_d  = '0;
         beats_d = head.beats;
         if (head.note >= 4'd1 && head.note <= 4'd12) begin
            freq_d = {23'd0, base_hz(head.note)} << head.oct;
            duty_d = DUTY_ON;
         end else begin
            freq_d = REST_FREQ;
            duty_d = 10'd0;
         end
      end

      if (flush) begin
         pop     = 1'b0;
         state_d = IDLE;
         cyc_d   = '0;
         beat_d  = '0;
         freq_d  = REST_FREQ;
         duty_d  = 10'd0;
         done_d  = 1'b0;
      end
   end

   // Sequencer state, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cyc_cnt   <= '0;
         beat_cnt  <= '0;
         beats_q   <= '0;
         freq      <= REST_FREQ;
         duty      <= 10'd0;
         note_done <= 1'b0;
      end else begin
         state     <= state_d;
         cyc_cnt   <= cyc_d;
         beat_cnt  <= beat_d;
         beats_q   <= beats_d;
         freq      <= freq_d;
         duty      <= duty_d;
         note_done <= done_d;
      end
   end

endmodule

// File: tb/tb_tone_queue.sv
// Directed testbench for tone_queue with BEAT_CYCLES=4, GAP_CYCLES=2, DEPTH=8.
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// so each check sees the values registered by the edge just passed.
module tb_tone_queue;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, flush, busy, note_done;
   logic [3:0]  in_note, level;
   logic [1:0]  in_oct, in_beats;
   logic [31:0] freq;
   logic [9:0]  duty;

   int n_tests  = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int d0;

   tone_queue #(
      .BEAT_CYCLES(4),
      .GAP_CYCLES (2),
      .DEPTH      (8),
      .DUTY_ON    (10'd512),
      .REST_FREQ  (32'd1000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_note  (in_note),
      .in_oct   (in_oct),
      .in_beats (in_beats),
      .flush    (flush),
      .freq     (freq),
      .duty     (duty),
      .busy     (busy),
      .note_done(note_done),
      .level    (level)
   );

   always #5 clk = ~clk;

   // Count note_done pulses as seen at each rising edge.
   always @(posedge clk) if (note_done === 1'b1) done_cnt++;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_note(input logic [3:0] n, input logic [1:0] o, input logic [1:0] b);
      in_valid = 1'b1;
      in_note  = n;
      in_oct   = o;
      in_beats = b;
      tick();
      in_valid = 1'b0;
   endtask

   // n further cycles of a sounding note with the given tone.
   task automatic play(input string tag, input logic [31:0] f, input logic [31:0] d, input int n);
      repeat (n) begin
         tick();
         check({tag, "_freq"}, freq, f);
         check({tag, "_duty"}, 32'(duty), d);
         check({tag, "_busy"}, 32'(busy), 32'd1);
      end
   endtask

   // PLAY end edge (note_done high, duty 0) followed by the second gap cycle.
   task automatic end_note(input string tag, input logic [31:0] f);
      tick();
      check({tag, "_end_freq"}, freq, f);
      check({tag, "_end_duty"}, 32'(duty), 32'd0);
      check({tag, "_end_done"}, 32'(note_done), 32'd1);
      tick();
      check({tag, "_gap_duty"}, 32'(duty), 32'd0);
      check({tag, "_gap_done"}, 32'(note_done), 32'd0);
      check({tag, "_gap_busy"}, 32'(busy), 32'd1);
   endtask

   task automatic idle_chk(input string tag);
      tick();
      check({tag, "_idle_freq"}, freq, 32'd1000);
      check({tag, "_idle_duty"}, 32'(duty), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic reset_vals(input string tag);
      check({tag, "_freq"}, freq, 32'd1000);
      check({tag, "_duty"}, 32'(duty), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(note_done), 32'd0);
      check({tag, "_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_level"}, 32'(level), 32'd0);
   endtask

   // Flush with an entry offered in the same cycle; nothing may survive.
   task automatic do_flush(input string tag);
      d0       = done_cnt;
      in_valid = 1'b1;
      in_note  = 4'd5;
      in_oct   = 2'd0;
      in_beats = 2'd0;
      flush    = 1'b1;
      #1;
      check({tag, "_ready_in_flush"}, 32'(in_ready), 32'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check({tag, "_level"}, 32'(level), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_duty"}, 32'(duty), 32'd0);
      check({tag, "_freq"}, freq, 32'd1000);
      check({tag, "_done"}, 32'(note_done), 32'd0);
      repeat (3) tick();
      check({tag, "_level_after"}, 32'(level), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
      check({tag, "_no_pulse"}, 32'(done_cnt - d0), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      flush    = 1'b0;
      in_note  = 4'd0;
      in_oct   = 2'd0;
      in_beats = 2'd0;

      // Reset state and in_ready rising right after release.
      tick();
      tick();
      reset_vals("rst");
      rst_n = 1'b1;
      tick();
      check("rdy_after_rst", 32'(in_ready), 32'd1);

      // Single note: A4, one beat.
      d0 = done_cnt;
      write_note(4'd10, 2'd0, 2'd0);
      check("t1_level", 32'(level), 32'd1);
      check("t1_idle_before_pop", 32'(busy), 32'd0);
      play("t1", 32'd440, 32'd512, 4);
      end_note("t1", 32'd440);
      idle_chk("t1");
      check("t1_pulses", 32'(done_cnt - d0), 32'd1);

      // Octave shift and chaining with no IDLE cycle between notes.
      d0 = done_cnt;
      write_note(4'd10, 2'd2, 2'd1);
      write_note(4'd1, 2'd3, 2'd1);
      check("t2_load_freq", freq, 32'd1760);
      check("t2_load_duty", 32'(duty), 32'd512);
      check("t2_level_wr_pop", 32'(level), 32'd1);
      play("t2a", 32'd1760, 32'd512, 7);
      end_note("t2a", 32'd1760);
      play("t2b", 32'd2096, 32'd512, 8);
      end_note("t2b", 32'd2096);
      idle_chk("t2");
      check("t2_pulses", 32'(done_cnt - d0), 32'd2);

      // Rest notes: code 0 for four beats, code 15 for one beat.
      d0 = done_cnt;
      write_note(4'd0, 2'd2, 2'd3);
      play("t4", 32'd1000, 32'd0, 16);
      end_note("t4", 32'd1000);
      idle_chk("t4");
      write_note(4'd15, 2'd1, 2'd0);
      play("t4b", 32'd1000, 32'd0, 4);
      end_note("t4b", 32'd1000);
      idle_chk("t4b");
      check("t4_pulses", 32'(done_cnt - d0), 32'd2);

      // Full FIFO: ten back-to-back offers, first popped, tenth dropped.
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_note  = 4'(i + 1);
         in_oct   = 2'd0;
         in_beats = 2'd3;
         tick();
         if (i == 1) check("t3_first_pop_freq", freq, 32'd262);
         if (i == 7) begin
            check("t3_level7", 32'(level), 32'd7);
            check("t3_ready7", 32'(in_ready), 32'd1);
         end
         if (i == 8) begin
            check("t3_level8", 32'(level), 32'd8);
            check("t3_ready8", 32'(in_ready), 32'd0);
         end
      end
      in_valid = 1'b0;
      check("t3_tenth_dropped", 32'(level), 32'd8);
      repeat (9) tick();
      check("t3_ready_in_gap", 32'(in_ready), 32'd0);
      check("t3_gap_duty", 32'(duty), 32'd0);
      check("t3_level_in_gap", 32'(level), 32'd8);
      tick();
      check("t3_ready_after_pop", 32'(in_ready), 32'd1);
      check("t3_level_after_pop", 32'(level), 32'd7);
      check("t3_second_freq", freq, 32'd277);
      check("t3_second_duty", 32'(duty), 32'd512);
      do_flush("t3_flush");

      // Flush mid-PLAY with three entries queued, landing on the PLAY end edge.
      write_note(4'd12, 2'd3, 2'd0);
      write_note(4'd14, 2'd3, 2'd0);
      write_note(4'd2, 2'd0, 2'd0);
      write_note(4'd3, 2'd0, 2'd0);
      check("t5_level", 32'(level), 32'd3);
      check("t5_freq", freq, 32'd3952);
      tick();
      check("t5_duty", 32'(duty), 32'd512);
      do_flush("t5_flush");

      // Reset mid-GAP with one entry queued, then a fresh note.
      write_note(4'd10, 2'd0, 2'd0);
      write_note(4'd2, 2'd0, 2'd0);
      check("t6_level", 32'(level), 32'd1);
      play("t6a", 32'd440, 32'd512, 3);
      tick();
      check("t6_in_gap_duty", 32'(duty), 32'd0);
      rst_n = 1'b0;
      tick();
      reset_vals("t6_rst");
      rst_n = 1'b1;
      tick();
      check("t6_ready", 32'(in_ready), 32'd1);
      tick();
      check("t6_still_idle", 32'(busy), 32'd0);
      d0 = done_cnt;
      write_note(4'd12, 2'd3, 2'd0);
      check("t6_wait_latency", 32'(busy), 32'd0);
      play("t6b", 32'd3952, 32'd512, 4);
      end_note("t6b", 32'd3952);
      idle_chk("t6b");
      check("t6_pulses", 32'(done_cnt - d0), 32'd1);

      // Reset on the edge that would have ended PLAY: no note_done.
      d0 = done_cnt;
      write_note(4'd3, 2'd0, 2'd0);
      play("t7", 32'd294, 32'd512, 4);
      rst_n = 1'b0;
      tick();
      reset_vals("t7_rst");
      rst_n = 1'b1;
      tick();
      tick();
      check("t7_no_pulse", 32'(done_cnt - d0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
